// File: rtl/common_axis_pkg.sv
// Shared AXI4-Stream video definitions: tuser flag positions and framer state encoding.
package common_axis_pkg;

  localparam int TUSER_SOF_BIT = 0;
  localparam int TUSER_EOF_BIT = 1;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_STREAM = 2'd1,
    FR_DRAIN  = 2'd2
  } framer_state_e;

endpackage

// File: rtl/common_axis_shim.sv
// One-stage AXI4-Stream register slice. With C_USE_RDY_MSK=0 a skid entry keeps s_axis_tready
// a pure flop output, so there is no combinational path from m_axis_tready back upstream.
module common_axis_shim #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_AXIS_TUSER_WIDTH = 2,
  parameter int C_USE_RDY_MSK      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);

  localparam int PW = C_AXIS_TDATA_WIDTH + C_AXIS_TUSER_WIDTH + 1;

  logic [PW-1:0] s_payload;
  logic [PW-1:0] out_data_q, out_data_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          accept;
  logic          out_load;

  assign s_payload = {s_axis_tlast, s_axis_tuser, s_axis_tdata};

  // Ready-mask variant trades the skid entry for a combinational ready path.
  assign s_axis_tready = (C_USE_RDY_MSK != 0) ? (!out_valid_q || m_axis_tready) : !skid_valid_q;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_load      = !out_valid_q || m_axis_tready;

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = s_payload;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_payload;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: payload registers are deliberately unreset; the valid flags alone qualify them.
  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  assign m_axis_tvalid = out_valid_q;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = out_data_q;

endmodule

// File: rtl/common_axis_framer.sv
// Video AXIS framer: turns an unframed pixel-word stream into frames of cfg_line_beats x
// cfg_frame_lines beats, marking SOF/EOF in tuser and end of line in tlast.
module common_axis_framer
  import common_axis_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_AXIS_TUSER_WIDTH = 2,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [C_CNT_WIDTH-1:0]          cfg_line_beats,
  input  logic [C_CNT_WIDTH-1:0]          cfg_frame_lines,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_pix_tdata,
  input  logic                            s_pix_tvalid,
  output logic                            s_pix_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            frame_active,
  output logic                            frame_done,
  output logic                            cfg_err
);

  typedef logic [C_CNT_WIDTH-1:0] cnt_t;

  framer_state_e state_q, state_d;
  cnt_t          beat_cnt_q, beat_cnt_d;
  cnt_t          line_cnt_q, line_cnt_d;
  cnt_t          line_beats_q, line_beats_d;
  cnt_t          frame_lines_q, frame_lines_d;
  logic          frame_active_q, frame_active_d;
  logic          frame_done_q, frame_done_d;
  logic          cfg_err_q, cfg_err_d;

  logic                          in_stream;
  logic                          shim_s_ready;
  logic                          pix_accept;
  logic                          last_beat;
  logic                          last_line;
  logic [C_AXIS_TUSER_WIDTH-1:0] pix_tuser;

  assign in_stream    = (state_q == FR_STREAM);
  assign s_pix_tready = shim_s_ready && in_stream;
  assign pix_accept   = s_pix_tvalid && s_pix_tready;

  // Compared against the values latched at frame start, never the live cfg inputs.
  assign last_beat = (beat_cnt_q == line_beats_q - cnt_t'(1));
  assign last_line = (line_cnt_q == frame_lines_q - cnt_t'(1));

  always_comb begin
    pix_tuser                = '0;
    pix_tuser[TUSER_SOF_BIT] = (beat_cnt_q == '0) && (line_cnt_q == '0);
    pix_tuser[TUSER_EOF_BIT] = last_beat && last_line;
  end

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_beats_d  = line_beats_q;
    frame_lines_d = frame_lines_q;
    cfg_err_d     = cfg_err_q;
    frame_done_d  = 1'b0;
    case (state_q)
      FR_IDLE: begin
        if (enable) begin
          if ((cfg_line_beats != '0) && (cfg_frame_lines != '0)) begin
            state_d       = FR_STREAM;
            line_beats_d  = cfg_line_beats;
            frame_lines_d = cfg_frame_lines;
            beat_cnt_d    = '0;
            line_cnt_d    = '0;
            cfg_err_d     = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      FR_STREAM: begin
        if (pix_accept) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            if (last_line) begin
              line_cnt_d = '0;
              state_d    = FR_DRAIN;
            end else begin
              line_cnt_d = line_cnt_q + cnt_t'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + cnt_t'(1);
          end
        end
      end
      FR_DRAIN: begin
        // The final beat has left the output register once tvalid drops.
        if (!m_axis_tvalid) begin
          state_d      = FR_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = FR_IDLE;
    endcase
    frame_active_d = (state_d != FR_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FR_IDLE;
      beat_cnt_q     <= '0;
      line_cnt_q     <= '0;
      line_beats_q   <= '0;
      frame_lines_q  <= '0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      line_cnt_q     <= line_cnt_d;
      line_beats_q   <= line_beats_d;
      frame_lines_q  <= frame_lines_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  common_axis_shim #(
    .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
    .C_AXIS_TUSER_WIDTH (C_AXIS_TUSER_WIDTH),
    .C_USE_RDY_MSK      (0)
  ) u_out_shim (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_pix_tdata),
    .s_axis_tuser  (pix_tuser),
    .s_axis_tlast  (last_beat),
    .s_axis_tvalid (s_pix_tvalid && in_stream),
    .s_axis_tready (shim_s_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  assign m_axis_tkeep = '1;
  assign m_axis_tstrb = '1;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign cfg_err      = cfg_err_q;

endmodule
